// File: rtl/fetch_ctrl_pkg.sv
// Purpose: shared types for the fetch-stage sequencer (FSM states, redirect cause).
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2
  } redirect_cause_t;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Purpose: free-running event counter, wraps modulo 2^CNT_W.
// Latency: count reflects an increment one cycle after inc is sampled.
// Backpressure: none; counts every cycle inc is high.
// Ports: clk, reset (sync, active-high), inc (event strobe), count (current value).
module fetch_perf_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             inc,
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q + CNT_W'(inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Purpose: instruction-fetch sequencer: PC mux selects, PC/IF-ID enables, pipeline flushes.
// Latency: control outputs are combinational from state + inputs (same cycle); state/counters registered.
// Backpressure: load_use stalls PC and IF/ID; imem_wait holds PC and bubbles ID; timeout latches FAULT.
// Ports: clk, reset (sync, active-high); branch_taken, jump_req, load_use, imem_wait in;
//        pc_select, jump_sel, pc_en, ifid_en, ifid_flush, idex_flush, fetch_fault, stall_cnt, flush_cnt out.
// Build option: FETCH_PERF_CNT_EN enables the stall/flush performance counters (otherwise tied to 0).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int WAIT_TIMEOUT    = 16,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_taken,
  input  logic             jump_req,
  input  logic             load_use,
  input  logic             imem_wait,
  output logic             pc_select,
  output logic             jump_sel,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // One shared down/up counter serves both the stall and the wait timer.
  localparam int CNT_MAX = (LU_STALL_CYCLES > WAIT_TIMEOUT) ? LU_STALL_CYCLES : WAIT_TIMEOUT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LU_LOAD = CW'(LU_STALL_CYCLES - 1);
  localparam logic [CW-1:0] WT_LAST = CW'(WAIT_TIMEOUT - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  fetch_state_t    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  redirect_cause_t cause;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause      = NONE;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    if (reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      cnt_d      = '0;
    end else if (state_q == FAULT) begin
      // Terminal until reset; every input is ignored.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (branch_taken) begin
      // Redirect wins over any stall or wait; PC loads even with imem_wait high.
      cause      = BRANCH;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      cnt_d      = '0;
    end else if (state_q == LU_STALL) begin
      // jump_req is deliberately ignored here; ID keeps presenting it.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      cnt_d      = cnt_q - ONE;
      if (cnt_q <= ONE) begin
        state_d = RUN;
      end
    end else if (load_use) begin
      // First bubble is this cycle; LU_STALL supplies the remaining LU_LOAD.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      cnt_d      = LU_LOAD;
      state_d    = (LU_LOAD != '0) ? LU_STALL : RUN;
    end else if (jump_req) begin
      cause      = JUMP;
      ifid_flush = 1'b1;
      state_d    = RUN;
      cnt_d      = '0;
    end else if (imem_wait) begin
      // Hold PC, push a bubble into ID while memory is busy.
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      if (state_q == MEM_WAIT) begin
        if (cnt_q >= WT_LAST) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        state_d = MEM_WAIT;
        cnt_d   = ONE;
      end
    end else begin
      state_d = RUN;
      cnt_d   = '0;
    end
  end

  assign pc_select   = (cause != NONE);
  assign jump_sel    = (cause == JUMP);
  assign fetch_fault = !reset && (state_q == FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall_inc;
  assign stall_inc = !reset && !pc_en;

  fetch_perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
    .inc   (stall_inc),
    .clk   (clk),
    .reset (reset),
    .count (stall_cnt)
  );

  fetch_perf_ctr #(.CNT_W(CNT_W)) u_flush_ctr (
    .inc   (pc_select),
    .clk   (clk),
    .reset (reset),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: directed self-checking bench for fetch_ctrl (LU_STALL_CYCLES=2, WAIT_TIMEOUT=16).
// Latency: outputs are checked 2 time units after each rising edge, once inputs have settled.
// Backpressure: n/a.
module tb_fetch_ctrl;

  localparam int CNT_W = 32;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, branch_taken, jump_req, load_use, imem_wait;
  logic pc_select, jump_sel, pc_en, ifid_en, ifid_flush, idex_flush, fetch_fault;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .LU_STALL_CYCLES (2),
    .WAIT_TIMEOUT    (16),
    .CNT_W           (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .branch_taken (branch_taken),
    .jump_req     (jump_req),
    .load_use     (load_use),
    .imem_wait    (imem_wait),
    .pc_select    (pc_select),
    .jump_sel     (jump_sel),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .fetch_fault  (fetch_fault),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // {pc_select, jump_sel, pc_en, ifid_flush, idex_flush, fetch_fault}
  logic [5:0] outs;
  assign outs = {pc_select, jump_sel, pc_en, ifid_flush, idex_flush, fetch_fault};

  localparam logic [5:0] O_RST   = 6'b000110;
  localparam logic [5:0] O_RUN   = 6'b001000;
  localparam logic [5:0] O_LU    = 6'b000010;
  localparam logic [5:0] O_BR    = 6'b101110;
  localparam logic [5:0] O_JMP   = 6'b111100;
  localparam logic [5:0] O_WAIT  = 6'b000100;
  localparam logic [5:0] O_FAULT = 6'b000111;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and apply new inputs just after the edge.
  task automatic drive(input logic r, input logic b, input logic j, input logic l, input logic w);
    @(posedge clk);
    #1;
    reset        = r;
    branch_taken = b;
    jump_req     = j;
    load_use     = l;
    imem_wait    = w;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; branch_taken = 1'b0; jump_req = 1'b0; load_use = 1'b0; imem_wait = 1'b0;

    // Reset held two cycles
    drive(1, 0, 0, 0, 0);
    check("rst1_outs", outs, O_RST);
    check("rst1_ifid_en", ifid_en, 1'b0);
    check("rst1_stall_cnt", stall_cnt, 0);
    drive(1, 0, 0, 0, 0);
    check("rst2_outs", outs, O_RST);
    check("rst2_flush_cnt", flush_cnt, 0);

    // First RUN cycle
    drive(0, 0, 0, 0, 0);
    check("run0_outs", outs, O_RUN);
    check("run0_ifid_en", ifid_en, 1'b1);
    check("run0_stall_cnt", stall_cnt, 0);

    // load_use pulse: exactly two bubbles
    drive(0, 0, 0, 1, 0);
    check("lu_c1", outs, O_LU);
    check("lu_c1_ifid_en", ifid_en, 1'b0);
    drive(0, 0, 0, 0, 0);
    check("lu_c2", outs, O_LU);
    drive(0, 0, 0, 0, 0);
    check("lu_done", outs, O_RUN);

    // branch in second stall cycle aborts the stall
    drive(0, 0, 0, 1, 0);
    check("lubr_c1", outs, O_LU);
    drive(0, 1, 0, 0, 0);
    check("lubr_branch", outs, O_BR);
    drive(0, 0, 0, 0, 0);
    check("lubr_after", outs, O_RUN);
    check("cnt_stall_3", stall_cnt, PERF ? 3 : 0);
    check("cnt_flush_1", flush_cnt, PERF ? 1 : 0);

    // jump + load_use: stall wins, jump taken once the stall ends
    drive(0, 0, 1, 1, 0);
    check("lujmp_c1", outs, O_LU);
    drive(0, 0, 1, 0, 0);
    check("lujmp_c2", outs, O_LU);
    drive(0, 0, 1, 0, 0);
    check("lujmp_jump", outs, O_JMP);
    drive(0, 0, 0, 0, 0);
    check("lujmp_after", outs, O_RUN);
    check("cnt_stall_5", stall_cnt, PERF ? 5 : 0);
    check("cnt_flush_2", flush_cnt, PERF ? 2 : 0);

    // branch beats jump
    drive(0, 1, 1, 0, 0);
    check("br_over_jmp", outs, O_BR);

    // short memory wait
    drive(0, 0, 0, 0, 1);
    check("wait1", outs, O_WAIT);
    check("wait1_ifid_en", ifid_en, 1'b1);
    drive(0, 0, 0, 0, 0);
    check("wait1_release", outs, O_RUN);

    // branch during MEM_WAIT redirects despite imem_wait
    drive(0, 0, 0, 0, 1);
    check("wbr_wait", outs, O_WAIT);
    drive(0, 1, 0, 0, 1);
    check("wbr_branch", outs, O_BR);
    drive(0, 0, 0, 0, 0);
    check("wbr_after", outs, O_RUN);

    // timeout: 16 wait cycles, then sticky fault
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 0, 1);
      check($sformatf("tmo_%0d", i), outs, (i <= 16) ? O_FAULT & 6'b000100 | 6'b000000 : O_FAULT);
    end
    drive(0, 1, 1, 1, 0);
    check("fault_sticky", outs, O_FAULT);
    check("fault_ifid_en", ifid_en, 1'b0);
    check("cnt_stall_27", stall_cnt, PERF ? 27 : 0);
    check("cnt_flush_4", flush_cnt, PERF ? 4 : 0);

    // only reset clears the fault
    drive(1, 0, 0, 0, 0);
    check("rst3_outs", outs, O_RST);
    drive(0, 0, 0, 0, 0);
    check("post_rst_outs", outs, O_RUN);
    check("post_rst_stall", stall_cnt, 0);
    check("post_rst_flush", flush_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
